// File: rtl/pet2001_kbd_pkg.sv
`default_nettype none
// ============================================================================
//  pet2001_kbd_pkg
//  Shared constants, receiver state encoding and scan-code map entry type.
//  Revision: 1.0
// ============================================================================
package pet2001_kbd_pkg;

    localparam logic [7:0] PS2_BREAK = 8'hF0;
    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BAT   = 8'hAA;
    localparam logic [7:0] PS2_ERR   = 8'hFF;
    localparam int         PET_ROWS  = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } key_map_t;

    function automatic key_map_t map_entry(input logic [3:0] row, input logic [2:0] col);
        key_map_t m;
        m.hit = 1'b1;
        m.row = row;
        m.col = col;
        return m;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  ps2_rx
//  PS/2 frame receiver: input synchronisers, 11-bit frame FSM and watchdog.
//  Revision: 1.0
// ============================================================================
module ps2_rx
    import pet2001_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       code_vld,
    output logic [7:0] code,
    output logic       rx_err
);

    localparam int c_WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic                   w_clk_s;
    logic                   w_dat_s;
    logic                   w_fall;

    ps2_state_e             r_state;
    ps2_state_e             w_next;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_par_ok;
    logic [c_WD_W-1:0]      r_wdog;
    logic                   w_timeout;
    logic                   w_vld;
    logic                   w_err;
    logic                   r_code_vld;
    logic                   r_err;

    // Idle PS/2 lines are high, so synchronisers reset to 1 to avoid a false edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
            r_clk_prev <= 1'b1;
        end else begin
            r_clk_sync[0] <= ps2_clk;
            r_dat_sync[0] <= ps2_data;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_clk_sync[i] <= r_clk_sync[i-1];
                r_dat_sync[i] <= r_dat_sync[i-1];
            end
            r_clk_prev <= w_clk_s;
        end
    end

    assign w_clk_s   = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s   = r_dat_sync[SYNC_STAGES-1];
    assign w_fall    = r_clk_prev & ~w_clk_s;
    assign w_timeout = (r_state != ST_IDLE) && !w_fall && (r_wdog == c_WD_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_timeout) begin
            w_next = ST_IDLE;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE:   w_next = w_dat_s ? ST_IDLE : ST_DATA;
                ST_DATA:   w_next = (r_bit_cnt == 3'd7) ? ST_PARITY : ST_DATA;
                ST_PARITY: w_next = ST_STOP;
                default:   w_next = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_vld = 1'b0;
        w_err = 1'b0;
        if (w_timeout) begin
            w_err = 1'b1;
        end else if (w_fall) begin
            if (r_state == ST_IDLE && w_dat_s) begin
                w_err = 1'b1;
            end
            if (r_state == ST_STOP) begin
                if (w_dat_s && r_par_ok) begin
                    w_vld = 1'b1;
                end else begin
                    w_err = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_par_ok  <= 1'b0;
        end else if (w_fall) begin
            case (r_state)
                ST_IDLE: r_bit_cnt <= '0;
                ST_DATA: begin
                    r_shift   <= {w_dat_s, r_shift[7:1]};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                ST_PARITY: r_par_ok <= ^{r_shift, w_dat_s};
                default: ;
            endcase
        end
    end

    // Counts clk cycles since the last PS/2 edge while a frame is in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state == ST_IDLE || w_fall || w_timeout) begin
            r_wdog <= '0;
        end else begin
            r_wdog <= r_wdog + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_code_vld <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_code_vld <= w_vld;
            r_err      <= w_err;
        end
    end

    assign code_vld = r_code_vld;
    assign code     = r_shift;
    assign rx_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/pet2001ps2_key.sv
`default_nettype none
// ============================================================================
//  pet2001ps2_key
//  PS/2 keyboard to PET 2001 10x8 key matrix with registered row readout.
//  Revision: 1.0
// ============================================================================
module pet2001ps2_key
    import pet2001_kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic [3:0] keyrow,
    output logic [7:0] keyin,
    output logic       kbd_err
);

    logic                      w_code_vld;
    logic [7:0]                w_code;
    logic                      w_rx_err;
    key_map_t                  w_map;
    logic                      w_fake_shift;
    logic                      r_brk_pend;
    logic                      r_ext_pend;
    logic [PET_ROWS-1:0][7:0]  r_matrix;
    logic [7:0]                r_keyin;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_ps2_rx (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .code_vld (w_code_vld),
        .code     (w_code),
        .rx_err   (w_rx_err)
    );

    assign kbd_err = w_rx_err;

    always_comb begin
        w_map = '0;
        case (w_code)
            8'h15: w_map = map_entry(4'd2, 3'd0);   // Q
            8'h24: w_map = map_entry(4'd2, 3'd1);   // E
            8'h2C: w_map = map_entry(4'd2, 3'd2);   // T
            8'h3C: w_map = map_entry(4'd2, 3'd3);   // U
            8'h1D: w_map = map_entry(4'd3, 3'd1);   // W
            8'h2D: w_map = map_entry(4'd3, 3'd2);   // R
            8'h35: w_map = map_entry(4'd3, 3'd3);   // Y
            8'h1C: w_map = map_entry(4'd4, 3'd0);   // A
            8'h23: w_map = map_entry(4'd4, 3'd1);   // D
            8'h34: w_map = map_entry(4'd4, 3'd2);   // G
            8'h3B: w_map = map_entry(4'd4, 3'd3);   // J
            8'h4B: w_map = map_entry(4'd4, 3'd4);   // L
            8'h1B: w_map = map_entry(4'd5, 3'd1);   // S
            8'h2B: w_map = map_entry(4'd5, 3'd2);   // F
            8'h33: w_map = map_entry(4'd5, 3'd3);   // H
            8'h42: w_map = map_entry(4'd5, 3'd4);   // K
            8'h1A: w_map = map_entry(4'd6, 3'd1);   // Z
            8'h21: w_map = map_entry(4'd6, 3'd2);   // C
            8'h32: w_map = map_entry(4'd6, 3'd3);   // B
            8'h5A: w_map = map_entry(4'd6, 3'd5);   // Enter
            8'h16: w_map = map_entry(4'd6, 3'd6);   // 1
            8'h26: w_map = map_entry(4'd6, 3'd7);   // 3
            8'h22: w_map = map_entry(4'd7, 3'd2);   // X
            8'h2A: w_map = map_entry(4'd7, 3'd3);   // V
            8'h31: w_map = map_entry(4'd7, 3'd4);   // N
            8'h1E: w_map = map_entry(4'd7, 3'd6);   // 2
            8'h12: w_map = map_entry(4'd8, 3'd0);   // L-Shift
            8'h3A: w_map = map_entry(4'd8, 3'd2);   // M
            8'h59: w_map = map_entry(4'd8, 3'd5);   // R-Shift
            8'h66: w_map = map_entry(4'd1, 3'd7);   // Backspace -> DEL
            8'h29: w_map = map_entry(4'd9, 3'd2);   // Space
            8'h76: w_map = map_entry(4'd9, 3'd4);   // Esc -> RUN/STOP
            default: w_map = '0;
        endcase
    end

    // Keyboards wrap some extended keys in E0 12 / E0 59 "fake shift" codes.
    assign w_fake_shift = r_ext_pend && (w_code == 8'h12 || w_code == 8'h59);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_brk_pend <= 1'b0;
            r_ext_pend <= 1'b0;
            r_matrix   <= '0;
        end else if (w_code_vld) begin
            if (w_code == PS2_BREAK) begin
                r_brk_pend <= 1'b1;
            end else if (w_code == PS2_EXT) begin
                r_ext_pend <= 1'b1;
            end else begin
                r_brk_pend <= 1'b0;
                r_ext_pend <= 1'b0;
                if (w_code == PS2_BAT || w_code == PS2_ERR) begin
                    r_matrix <= '0;
                end else if (w_map.hit && !w_fake_shift) begin
                    r_matrix[w_map.row][w_map.col] <= !r_brk_pend;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_keyin <= 8'hFF;
        end else if (keyrow < 4'(PET_ROWS)) begin
            r_keyin <= ~r_matrix[keyrow];
        end else begin
            r_keyin <= 8'hFF;
        end
    end

    assign keyin = r_keyin;

endmodule
`default_nettype wire

// File: tb/tb_pet2001ps2_key.sv
`default_nettype none
// ============================================================================
//  tb_pet2001ps2_key
//  Directed bench: PS/2 frames in, PET matrix rows checked via keyrow/keyin.
//  Revision: 1.0
// ============================================================================
module tb_pet2001ps2_key;

    localparam int c_TIMEOUT = 300;
    localparam int c_HALF    = 15;

    logic       clk;
    logic       reset;
    logic       ps2_clk;
    logic       ps2_data;
    logic [3:0] keyrow;
    logic [7:0] keyin;
    logic       kbd_err;

    int n_vec;
    int n_err;
    int err_cnt;

    pet2001ps2_key #(
        .TIMEOUT_CYCLES (c_TIMEOUT),
        .SYNC_STAGES    (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .keyrow   (keyrow),
        .keyin    (keyin),
        .kbd_err  (kbd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (kbd_err === 1'b1) err_cnt <= err_cnt + 1;
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_data = b;
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (c_HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] c, input logic flip);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(c[i]);
        ps2_bit(~(^c) ^ flip);
        ps2_bit(1'b1);
        repeat (20) @(negedge clk);
    endtask

    task automatic set_row(input logic [3:0] r);
        @(negedge clk);
        keyrow = r;
        @(posedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        n_vec++;
        if (kbd_err !== 1'b0) begin
            $display("FAIL reset_err: got %b want 0", kbd_err);
            n_err++;
        end
        for (int r = 0; r < 16; r++) begin
            set_row(4'(r));
            n_vec++;
            if (keyin !== 8'hFF) begin
                $display("FAIL reset_row%0d: got %h want ff", r, keyin);
                n_err++;
            end
        end
    endtask

    task automatic test_make_break;
        send_frame(8'h1C, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFE) begin
            $display("FAIL make_A: got %h want fe", keyin);
            n_err++;
        end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h1C, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL break_A: got %h want ff", keyin);
            n_err++;
        end
    endtask

    task automatic test_multi_key;
        send_frame(8'h12, 1'b0);
        send_frame(8'h5A, 1'b0);
        set_row(4'd8);
        n_vec++;
        if (keyin !== 8'hFE) begin
            $display("FAIL multi_shift: got %h want fe", keyin);
            n_err++;
        end
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hDF) begin
            $display("FAIL multi_enter: got %h want df", keyin);
            n_err++;
        end
        send_frame(8'hF0, 1'b0);
        send_frame(8'h12, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        set_row(4'd8);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL multi_rel_shift: got %h want ff", keyin);
            n_err++;
        end
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL multi_rel_enter: got %h want ff", keyin);
            n_err++;
        end
    endtask

    task automatic test_parity_err;
        int e0;
        e0 = err_cnt;
        send_frame(8'h1C, 1'b1);
        n_vec++;
        if (err_cnt - e0 !== 1) begin
            $display("FAIL parity_err_pulses: got %0d want 1", err_cnt - e0);
            n_err++;
        end
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL parity_drop: got %h want ff", keyin);
            n_err++;
        end
        send_frame(8'h1C, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFE) begin
            $display("FAIL parity_recover: got %h want fe", keyin);
            n_err++;
        end
        // Break prefix must survive a corrupted frame in between.
        send_frame(8'hF0, 1'b0);
        send_frame(8'h33, 1'b1);
        send_frame(8'h1C, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL prefix_persist: got %h want ff", keyin);
            n_err++;
        end
    endtask

    task automatic test_extended;
        int e0;
        e0 = err_cnt;
        send_frame(8'hE0, 1'b0);
        send_frame(8'h12, 1'b0);
        set_row(4'd8);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL ext_fake_shift: got %h want ff", keyin);
            n_err++;
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'h5A, 1'b0);
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hDF) begin
            $display("FAIL ext_enter: got %h want df", keyin);
            n_err++;
        end
        send_frame(8'hE0, 1'b0);
        send_frame(8'hF0, 1'b0);
        send_frame(8'h5A, 1'b0);
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL ext_enter_break: got %h want ff", keyin);
            n_err++;
        end
        n_vec++;
        if (err_cnt !== e0) begin
            $display("FAIL ext_no_err: got %0d want %0d", err_cnt, e0);
            n_err++;
        end
    endtask

    task automatic test_bad_start;
        int e0;
        e0 = err_cnt;
        ps2_bit(1'b1);
        repeat (10) @(negedge clk);
        n_vec++;
        if (err_cnt - e0 !== 1) begin
            $display("FAIL bad_start_pulses: got %0d want 1", err_cnt - e0);
            n_err++;
        end
        send_frame(8'h16, 1'b0);
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hBF) begin
            $display("FAIL bad_start_recover: got %h want bf", keyin);
            n_err++;
        end
    endtask

    task automatic test_back_to_back;
        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b0);
        send_frame(8'h29, 1'b0);
        set_row(4'd9);
        n_vec++;
        if (keyin !== 8'hFB) begin
            $display("FAIL repeat_space: got %h want fb", keyin);
            n_err++;
        end
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hBF) begin
            $display("FAIL held_one: got %h want bf", keyin);
            n_err++;
        end
        send_frame(8'hAA, 1'b0);
        set_row(4'd9);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL bat_clear_row9: got %h want ff", keyin);
            n_err++;
        end
        set_row(4'd6);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL bat_clear_row6: got %h want ff", keyin);
            n_err++;
        end
        send_frame(8'h1C, 1'b0);
        send_frame(8'hFF, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL ff_clear_row4: got %h want ff", keyin);
            n_err++;
        end
        set_row(4'd12);
        n_vec++;
        if (keyin !== 8'hFF) begin
            $display("FAIL row12_blank: got %h want ff", keyin);
            n_err++;
        end
    endtask

    task automatic test_timeout;
        int e0;
        logic [7:0] c;
        c = 8'h29;
        e0 = err_cnt;
        ps2_bit(1'b0);
        for (int i = 0; i < 5; i++) ps2_bit(c[i]);
        ps2_data = 1'b1;
        repeat (c_TIMEOUT + 10) @(negedge clk);
        n_vec++;
        if (err_cnt - e0 !== 1) begin
            $display("FAIL timeout_pulses: got %0d want 1", err_cnt - e0);
            n_err++;
        end
        send_frame(8'h29, 1'b0);
        set_row(4'd9);
        n_vec++;
        if (keyin !== 8'hFB) begin
            $display("FAIL timeout_recover: got %h want fb", keyin);
            n_err++;
        end
        e0 = err_cnt;
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        @(negedge clk);
        reset = 1'b1;
        ps2_data = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int r = 0; r < 10; r++) begin
            set_row(4'(r));
            n_vec++;
            if (keyin !== 8'hFF) begin
                $display("FAIL midreset_row%0d: got %h want ff", r, keyin);
                n_err++;
            end
        end
        send_frame(8'h1C, 1'b0);
        set_row(4'd4);
        n_vec++;
        if (keyin !== 8'hFE) begin
            $display("FAIL midreset_next: got %h want fe", keyin);
            n_err++;
        end
        n_vec++;
        if (err_cnt !== e0) begin
            $display("FAIL midreset_no_err: got %0d want %0d", err_cnt, e0);
            n_err++;
        end
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        err_cnt  = 0;
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        keyrow   = 4'd0;
        repeat (5) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        test_reset;
        test_make_break;
        test_multi_key;
        test_parity_err;
        test_extended;
        test_bad_start;
        test_back_to_back;
        test_timeout;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pet2001ps2_key.md
# pet2001ps2_key

Converts a PS/2 keyboard serial stream into the Commodore PET 2001 key-matrix model. The block decodes make/break scan codes, maintains a 10×8 key-state matrix, and answers row-select queries. It sits directly upstream of `pet2001_top`: it drives that block's `keyin[7:0]` and consumes its `keyrow[3:0]`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: `clk` cycles with no PS/2 falling edge before a partial frame is discarded (1 ms at 50 MHz).
- `SYNC_STAGES`, default 2: synchroniser depth for `ps2_clk` and `ps2_data`.

Ports:
- `clk` — in, 1: system clock, the same clock that feeds `pet2001_top`.
- `reset` — in, 1: asynchronous, active-high reset.
- `ps2_clk` — in, 1: raw PS/2 clock, asynchronous to `clk`.
- `ps2_data` — in, 1: raw PS/2 data, asynchronous to `clk`.
- `keyrow` — in, 4: PET row select, 0–9 valid.
- `keyin` — out, 8: active-low column bits for the selected row.
- `kbd_err` — out, 1: one-cycle pulse on a framing, parity or timeout error.

## Operation
- **Input synchronisation:** pass `ps2_clk` and `ps2_data` through `SYNC_STAGES` flops.
- **Bit sampling:** a falling edge on synchronised `ps2_clk` samples `ps2_data`.
- **Frame receiver FSM:** states IDLE, DATA, PARITY, STOP.
  - IDLE → DATA on a sampled start bit of 0. A start bit of 1 stays in IDLE and pulses `kbd_err`.
  - DATA shifts 8 bits, LSB first, using a 3-bit counter, then → PARITY.
  - PARITY checks for odd parity over data plus parity bit, then → STOP.
  - STOP: stop bit = 1 and parity OK → `code_vld` pulse with `code[7:0]`. Otherwise `kbd_err` pulse and the code is dropped. Either way → IDLE.
  - Watchdog: outside IDLE, `TIMEOUT_CYCLES` without an edge → IDLE with a `kbd_err` pulse.
- **Decoder, acting on `code_vld`:**
  - `F0` sets `brk_pend`.
  - `E0` sets `ext_pend`.
  - Any other code is looked up in the map → (`hit`, `row[3:0]`, `col[2:0]`).
  - On `hit`: set `matrix[row][col]` for a make, clear it for a break.
  - Clear `brk_pend` and `ext_pend` after every non-prefix code.
  - An extended code with `ext_pend` = 1 and code `12` or `59` (fake shift) is ignored.
  - Other extended codes map as their base code.
  - Unmapped codes only clear the prefixes.
  - Code `AA` (BAT OK) or `FF` clears the entire matrix.
- **Matrix read:** 10 rows × 8 bits, 1 = pressed.
  - `keyin <= ~matrix[keyrow]` for `keyrow` 0–9.
  - `keyin <= 8'hFF` for `keyrow` 10–15.

## Timing
- **Reset values:** FSM IDLE, matrix all 0, prefixes 0, `keyin` = 8'hFF, `kbd_err` = 0, synchronisers 1.
- **Read latency:** `keyin` is registered; it reflects `keyrow` one `clk` after `keyrow` changes.
- **Update latency:** a matrix update is visible on `keyin` no later than `SYNC_STAGES` + 3 cycles after the stop-bit falling edge.
- **Collision:** a matrix write and a read of the same row in one cycle → `keyin` shows the pre-write value that cycle and the new value the next cycle.
- **Multiple keys:** held keys are independent, with no rollover limit.
- **Repeat makes:** typematic repeats rewrite 1, with no side effect.
- **Reset mid-frame:** the frame is abandoned and the matrix is cleared. The next start bit is decoded normally.
- **Prefix persistence:** `brk_pend` / `ext_pend` survive a frame error and are only cleared by the next valid non-prefix code or by reset.

## Structure
- **Package `pet2001_kbd_pkg`:**
  - Constants: `PS2_BREAK` = 8'hF0, `PS2_EXT` = 8'hE0, `PS2_BAT` = 8'hAA, `PET_ROWS` = 10.
  - FSM state enum.
  - Packed struct `{hit, row[3:0], col[2:0]}`.
- **Sub-module `ps2_rx`:** synchronisers, FSM and watchdog. Outputs `code_vld`, `code[7:0]`, `rx_err`.
- **Scan-code map:** a combinational `case` in the top module. It includes:
  - `1C` ('A') → row 4, col 0.
  - `5A` (Enter) → row 6, col 5.
  - `12` (L-Shift) → row 8, col 0.
  - `29` (Space) → row 9, col 2.
  - `16` ('1') → row 6, col 6.

## Test plan
1. Reset, with `keyrow` swept 0–15 → `keyin` = 8'hFF for every row.
2. Send frame `1C` and hold `keyrow` = 4 → `keyin` = 8'hFE. Then send `F0 1C` → `keyin` = 8'hFF.
3. Send `12`, then `5A`:
   - `keyrow` = 8 → 8'hFE.
   - `keyrow` = 6 → 8'hDF.
   - Release both → 8'hFF.
4. Send `1C` with the parity bit flipped → one `kbd_err` pulse, row 4 stays 8'hFF. The following good `1C` → 8'hFE.
5. Send `E0 12` → no matrix change. Send `E0 5A` → row 6 = 8'hDF.
6. Stop after 5 data bits and wait `TIMEOUT_CYCLES` + 1 → `kbd_err` pulse. The next full `29` frame → row 9 = 8'hFB. Asserting `reset` mid-frame → all rows 8'hFF.
